// File: rtl/trace_fetch_scheduler_if.sv
// Bus bundle for trace_fetch_scheduler.
//   CPU side    : cpu_req/cpu_addr in, cpu_gnt/cpu_rvalid/cpu_rdata out
//   Memory side : mem_addr out, mem_rdata in (one-cycle read latency)
//   Line buffer : buf_we/buf_chan/buf_idx/buf_data out
//   Control     : frame_start in, busy/overrun out
// master = the environment (CPU, memory, display timing); slave = the scheduler.
interface trace_fetch_scheduler_if;
  logic        frame_start;
  logic        cpu_req;
  logic [11:0] cpu_addr;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic [11:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        buf_we;
  logic        buf_chan;
  logic [8:0]  buf_idx;
  logic [7:0]  buf_data;
  logic        busy;
  logic        overrun;

  modport master (
    output frame_start, cpu_req, cpu_addr, mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, mem_addr,
    input  buf_we, buf_chan, buf_idx, buf_data, busy, overrun
  );

  modport slave (
    input  frame_start, cpu_req, cpu_addr, mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, mem_addr,
    output buf_we, buf_chan, buf_idx, buf_data, busy, overrun
  );
endinterface

// File: rtl/trace_fetch_scheduler.sv
// Trace fetch scheduler: on each frame_start, streams SAMPLES words of channel 0 (ECG) and then
// SAMPLES words of channel 1 (EMG) from sample memory into the display line buffer, sharing the
// memory read port with a CPU. The CPU wins arbitration, but after CPU_RUN_MAX consecutive CPU
// grants during a fetch the display gets one slot so the fetch cannot starve.
// Ports:
//   clk, rst      : system clock, asynchronous active-high reset
//   bus (slave)   : frame_start, CPU request/grant/read-data, memory address/data,
//                   line-buffer write port, busy and sticky overrun status
module trace_fetch_scheduler #(
  parameter logic [11:0] CH0_BASE    = 12'h559,
  parameter logic [11:0] CH1_BASE    = 12'h6AD,
  parameter int unsigned SAMPLES     = 320,
  parameter int unsigned CPU_RUN_MAX = 4
) (
  input logic                     clk,
  input logic                     rst,
  trace_fetch_scheduler_if.slave  bus
);

  localparam int unsigned RunW = $clog2(CPU_RUN_MAX + 1);

  typedef enum logic [1:0] {StIdle, StCh0, StCh1} state_e;

  state_e            state_q, state_d;
  logic [8:0]        issue_cnt_q, issue_cnt_d;
  logic [RunW-1:0]   run_cnt_q, run_cnt_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              buf_we_q, buf_we_d;
  logic              buf_chan_q, buf_chan_d;
  logic [8:0]        buf_idx_q, buf_idx_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;

  logic              active;
  logic              run_full;
  logic              cpu_gnt;
  logic              disp_gnt;
  logic              last_issue;
  logic [11:0]       disp_addr;

  // Arbitration and address mux.
  always_comb begin
    active     = (state_q != StIdle);
    run_full   = active && (run_cnt_q == RunW'(CPU_RUN_MAX));
    cpu_gnt    = bus.cpu_req && !run_full;
    disp_gnt   = active && !cpu_gnt;
    last_issue = (issue_cnt_q == 9'(SAMPLES - 1));
    // 12-bit add wraps modulo 4096.
    disp_addr  = ((state_q == StCh1) ? CH1_BASE : CH0_BASE) + {3'b000, issue_cnt_q};
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    run_cnt_d    = run_cnt_q;
    overrun_d    = overrun_q;
    buf_we_d     = disp_gnt;
    buf_chan_d   = buf_chan_q;
    buf_idx_d    = buf_idx_q;
    cpu_rvalid_d = cpu_gnt;

    if (disp_gnt) begin
      buf_chan_d = (state_q == StCh1);
      buf_idx_d  = issue_cnt_q;
    end

    unique case (state_q)
      StIdle: begin
        run_cnt_d = '0;
        if (bus.frame_start) begin
          state_d     = StCh0;
          issue_cnt_d = '0;
          overrun_d   = 1'b0;
          buf_we_d    = 1'b0;
          buf_chan_d  = 1'b0;
          buf_idx_d   = '0;
        end
      end
      StCh0, StCh1: begin
        // A frame_start during a fetch (including on its last grant) never restarts it.
        if (bus.frame_start) overrun_d = 1'b1;
        if (cpu_gnt) run_cnt_d = run_cnt_q + 1'b1;
        if (disp_gnt) begin
          run_cnt_d = '0;
          if (last_issue) begin
            issue_cnt_d = '0;
            state_d     = (state_q == StCh0) ? StCh1 : StIdle;
          end else begin
            issue_cnt_d = issue_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      issue_cnt_q  <= '0;
      run_cnt_q    <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      buf_we_q     <= 1'b0;
      buf_chan_q   <= 1'b0;
      buf_idx_q    <= '0;
      cpu_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      run_cnt_q    <= run_cnt_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      buf_we_q     <= buf_we_d;
      buf_chan_q   <= buf_chan_d;
      buf_idx_q    <= buf_idx_d;
      cpu_rvalid_q <= cpu_rvalid_d;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.mem_addr   = disp_gnt ? disp_addr : bus.cpu_addr;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.buf_we     = buf_we_q;
  assign bus.buf_chan   = buf_chan_q;
  assign bus.buf_idx    = buf_idx_q;
  // Memory output is already registered one cycle after the grant, so it lines up with buf_we;
  // forced to zero outside a write so the port is quiet when idle and in reset.
  assign bus.buf_data   = buf_we_q ? bus.mem_rdata[11:4] : 8'h00;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_trace_fetch_scheduler.sv
module tb_trace_fetch_scheduler;

  localparam logic [11:0] Ch0Base = 12'h559;
  localparam logic [11:0] Ch1Base = 12'h6AD;
  localparam int          Samples = 320;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  trace_fetch_scheduler_if tif ();

  trace_fetch_scheduler #(
    .CH0_BASE    (12'h559),
    .CH1_BASE    (12'h6AD),
    .SAMPLES     (320),
    .CPU_RUN_MAX (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (tif)
  );

  // Sample memory: each word holds its own address, one-cycle read latency.
  always @(posedge clk) tif.mem_rdata <= {20'h0, tif.mem_addr};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one frame fetch and scoreboards every line-buffer write against the expected stream.
  // fs_at: busy-cycle index at which an extra frame_start is injected (-1 = none).
  task automatic run_fetch(input bit cpu_hold, input int fs_at,
                           output int busy_cyc, output int n_wr, output int wr_span,
                           output int ch1_first_cyc, output logic first_ovr,
                           output logic end_ovr, output logic [11:0] last_disp);
    int          cyc = 0;
    int          k = 0;
    int          first_wr = -1;
    int          last_wr = -1;
    bit          seen = 1'b0;
    bit          done = 1'b0;
    logic [8:0]  exp_idx = '0;
    logic        exp_chan = 1'b0;
    logic [11:0] a;
    busy_cyc = 0;
    n_wr = 0;
    ch1_first_cyc = -1;
    first_ovr = 1'b0;
    last_disp = '0;
    @(negedge clk);
    tif.cpu_req     = cpu_hold;
    tif.frame_start = 1'b1;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      tif.frame_start = 1'b0;
      if (cyc == 0) first_ovr = tif.overrun;
      if (tif.buf_we) begin
        a = (exp_chan ? Ch1Base : Ch0Base) + {3'b000, exp_idx};
        check_eq("buf_write", {14'h0, tif.buf_chan, tif.buf_idx, tif.buf_data},
                 {14'h0, exp_chan, exp_idx, a[11:4]});
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        n_wr++;
        if (tif.buf_chan && tif.buf_idx == 9'd0 && ch1_first_cyc < 0) ch1_first_cyc = cyc;
        if (exp_idx == 9'(Samples - 1)) begin
          exp_idx  = '0;
          exp_chan = 1'b1;
        end else begin
          exp_idx = exp_idx + 1'b1;
        end
      end
      if (tif.busy) begin
        seen = 1'b1;
        if (cpu_hold && k < 10) check_eq("cpu_gnt_pattern", {31'h0, tif.cpu_gnt},
                                         {31'h0, ((k % 5) != 4)});
        if (!tif.cpu_gnt) last_disp = tif.mem_addr;
        if (k == fs_at) tif.frame_start = 1'b1;
        k++;
        busy_cyc++;
      end else if (seen) begin
        done = 1'b1;
      end
      cyc++;
    end
    if (!done) check_eq("fetch_timeout", 32'd0, 32'd1);
    end_ovr = tif.overrun;
    wr_span = last_wr - first_wr + 1;
    tif.cpu_req = 1'b0;
  endtask

  int          busy_cyc, n_wr, wr_span, ch1_first;
  logic        first_ovr, end_ovr;
  logic [11:0] last_disp;
  int          stray;
  bit          hit;

  initial begin
    rst             = 1'b1;
    tif.frame_start = 1'b0;
    tif.cpu_req     = 1'b1;
    tif.cpu_addr    = 12'h0AB;

    // Reset state; CPU still granted combinationally while in reset.
    #2;
    check_eq("rst_busy", {31'h0, tif.busy}, 32'd0);
    check_eq("rst_overrun", {31'h0, tif.overrun}, 32'd0);
    check_eq("rst_buf_we", {31'h0, tif.buf_we}, 32'd0);
    check_eq("rst_buf_chan", {31'h0, tif.buf_chan}, 32'd0);
    check_eq("rst_buf_idx", {23'h0, tif.buf_idx}, 32'd0);
    check_eq("rst_buf_data", {24'h0, tif.buf_data}, 32'd0);
    check_eq("rst_cpu_gnt", {31'h0, tif.cpu_gnt}, 32'd1);
    check_eq("rst_mem_addr", {20'h0, tif.mem_addr}, 32'h0AB);
    @(negedge clk);
    check_eq("rst_cpu_rvalid", {31'h0, tif.cpu_rvalid}, 32'd0);
    rst         = 1'b0;
    tif.cpu_req = 1'b0;

    // CPU read while idle.
    @(negedge clk);
    check_eq("idle_no_busy", {31'h0, tif.busy}, 32'd0);
    tif.cpu_req  = 1'b1;
    tif.cpu_addr = 12'h123;
    #1;
    check_eq("idle_cpu_gnt", {31'h0, tif.cpu_gnt}, 32'd1);
    check_eq("idle_mem_addr", {20'h0, tif.mem_addr}, 32'h123);
    @(negedge clk);
    check_eq("idle_cpu_rvalid", {31'h0, tif.cpu_rvalid}, 32'd1);
    check_eq("idle_cpu_rdata", tif.cpu_rdata, 32'h123);
    tif.cpu_req = 1'b0;
    @(negedge clk);
    check_eq("idle_rvalid_drop", {31'h0, tif.cpu_rvalid}, 32'd0);

    // Plain fetch with no CPU traffic.
    run_fetch(1'b0, -1, busy_cyc, n_wr, wr_span, ch1_first, first_ovr, end_ovr, last_disp);
    check_eq("idle_fetch_busy", busy_cyc, 32'd640);
    check_eq("idle_fetch_writes", n_wr, 32'd640);
    check_eq("idle_fetch_span", wr_span, 32'd640);
    check_eq("idle_fetch_ch1_start", ch1_first, 32'd321);
    check_eq("idle_fetch_last_addr", {20'h0, last_disp}, 32'h7EC);
    check_eq("idle_fetch_overrun", {31'h0, end_ovr}, 32'd0);

    // CPU hammering the port: display gets every fifth slot.
    tif.cpu_addr = 12'h0AB;
    run_fetch(1'b1, -1, busy_cyc, n_wr, wr_span, ch1_first, first_ovr, end_ovr, last_disp);
    check_eq("starve_busy", busy_cyc, 32'd3200);
    check_eq("starve_writes", n_wr, 32'd640);
    check_eq("starve_ch1_start", ch1_first, 32'd1605);
    check_eq("starve_last_addr", {20'h0, last_disp}, 32'h7EC);

    // Overrun mid-fetch: fetch unaffected, flag sticky.
    run_fetch(1'b0, 100, busy_cyc, n_wr, wr_span, ch1_first, first_ovr, end_ovr, last_disp);
    check_eq("ovr_busy", busy_cyc, 32'd640);
    check_eq("ovr_writes", n_wr, 32'd640);
    check_eq("ovr_set", {31'h0, end_ovr}, 32'd1);

    // Next frame_start clears it; frame_start on the very last grant sets it, no restart.
    run_fetch(1'b0, 639, busy_cyc, n_wr, wr_span, ch1_first, first_ovr, end_ovr, last_disp);
    check_eq("ovr_cleared", {31'h0, first_ovr}, 32'd0);
    check_eq("ovr_last_busy", busy_cyc, 32'd640);
    check_eq("ovr_last_set", {31'h0, end_ovr}, 32'd1);
    repeat (5) @(negedge clk);
    check_eq("ovr_last_no_restart", {31'h0, tif.busy}, 32'd0);

    // Reset in the middle of channel 1.
    @(negedge clk);
    tif.frame_start = 1'b1;
    @(negedge clk);
    tif.frame_start = 1'b0;
    repeat (10) @(negedge clk);
    tif.frame_start = 1'b1;
    @(negedge clk);
    tif.frame_start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge clk);
      if (tif.buf_we && tif.buf_chan && tif.buf_idx == 9'd50) hit = 1'b1;
    end
    check_eq("mid_reached_ch1_50", {31'h0, hit}, 32'd1);
    check_eq("mid_overrun_before", {31'h0, tif.overrun}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", {31'h0, tif.busy}, 32'd0);
    check_eq("mid_rst_buf_we", {31'h0, tif.buf_we}, 32'd0);
    check_eq("mid_rst_overrun", {31'h0, tif.overrun}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (tif.buf_we || tif.busy) stray++;
    end
    check_eq("post_rst_quiet", stray, 32'd0);
    run_fetch(1'b0, -1, busy_cyc, n_wr, wr_span, ch1_first, first_ovr, end_ovr, last_disp);
    check_eq("post_rst_writes", n_wr, 32'd640);
    check_eq("post_rst_busy", busy_cyc, 32'd640);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
